des_decrypt_key_schedule: RTL and testbench

//  Sequential DES key scheduler for the decryption direction. Takes a 64-bit key and streams the 16
//  48-bit round subkeys in reverse order (K16 first, K1 last), one per handshake. It feeds the

---
 rtl/des_decrypt_key_schedule_if.sv | 44 ++++
 rtl/des_decrypt_key_schedule.sv | 108 ++++++++++
 tb/tb_des_decrypt_key_schedule.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/des_decrypt_key_schedule_if.sv
// des_decrypt_key_schedule_if: key-load and subkey-stream handshake bundle for the DES key scheduler.
// Signals (named from the scheduler's point of view):
//   i_key[63:0]       DES key, index k = FIPS bit k+1
//   i_key_valid       key offered
//   o_key_ready       scheduler idle, key accepted on valid&&ready
//   o_subkey[47:0]    current round subkey, index k = FIPS bit k+1
//   o_subkey_valid    subkey offered
//   i_subkey_ready    round engine takes the subkey
//   o_round_idx[3:0]  round number minus 1 of the current subkey
//   o_last_round      final subkey of the schedule is on the bus
//   o_key_parity_err  loaded key had an even-parity byte
//   i_decrypt         (DES_KS_BIDIR_EN only) 1 = K16..K1, 0 = K1..K16
// Modports: slave = scheduler, master = key source / round engine side.
interface des_decrypt_key_schedule_if;
   logic [63:0] i_key;
   logic        i_key_valid;
   logic        o_key_ready;
   logic [47:0] o_subkey;
   logic        o_subkey_valid;
   logic        i_subkey_ready;
   logic [3:0]  o_round_idx;
   logic        o_last_round;
   logic        o_key_parity_err;
`ifdef DES_KS_BIDIR_EN
   logic        i_decrypt;
   modport slave (
      input  i_key, i_key_valid, i_subkey_ready, i_decrypt,
      output o_key_ready, o_subkey, o_subkey_valid, o_round_idx, o_last_round, o_key_parity_err
   );
   modport master (
      output i_key, i_key_valid, i_subkey_ready, i_decrypt,
      input  o_key_ready, o_subkey, o_subkey_valid, o_round_idx, o_last_round, o_key_parity_err
   );
`else
   modport slave (
      input  i_key, i_key_valid, i_subkey_ready,
      output o_key_ready, o_subkey, o_subkey_valid, o_round_idx, o_last_round, o_key_parity_err
   );
   modport master (
      output i_key, i_key_valid, i_subkey_ready,
      input  o_key_ready, o_subkey, o_subkey_valid, o_round_idx, o_last_round, o_key_parity_err
   );
`endif
endinterface

// File: rtl/des_decrypt_key_schedule.sv
// des_decrypt_key_schedule: sequential DES key scheduler streaming K16..K1 (one per handshake).
// Ports:
//   i_clk   clock, all state on rising edge
//   i_rst   asynchronous active-high reset
//   io_ks   des_decrypt_key_schedule_if.slave (key in, subkey out, round index, parity flag)
// Parameter PARITY_CHECK: 1 flags even-parity key bytes on o_key_parity_err, 0 ties it low.
// Macro DES_KS_BIDIR_EN: adds i_decrypt; i_decrypt=0 at load streams K1..K16 instead.
module des_decrypt_key_schedule #(
   parameter bit PARITY_CHECK = 1'b0
) (
   input  logic                             i_clk,
   input  logic                             i_rst,
   des_decrypt_key_schedule_if.slave        io_ks
);
   typedef enum logic {IDLE, RUN} state_t;
   localparam int PC1 [56] = '{
      57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
      10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
      14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
   localparam int PC2 [48] = '{
      14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
   state_t      r_state, w_state_nxt;
   logic [27:0] r_c, r_d, w_c_nxt, w_d_nxt, w_c_pc1, w_d_pc1;
   logic [3:0]  r_idx, w_idx_nxt, w_sidx;
   logic        r_perr, w_perr_nxt;
   logic [55:0] w_cd;
   logic [47:0] w_sub;
   logic [7:0]  w_bad;
   logic        w_dec, w_dec_ld, w_load, w_xfer, w_last, w_two;
   // Rotation toward higher FIPS bit numbers is toward higher vector index.
   function automatic logic [27:0] rotr(input logic [27:0] v, input logic two);
      return two ? {v[25:0], v[27:26]} : {v[26:0], v[27]};
   endfunction
   function automatic logic [27:0] rotl(input logic [27:0] v, input logic two);
      return two ? {v[1:0], v[27:2]} : {v[0], v[27:1]};
   endfunction
`ifdef DES_KS_BIDIR_EN
   logic r_dec;
   assign w_dec_ld = io_ks.i_decrypt;
   assign w_dec    = r_dec;
   always_ff @(posedge i_clk or posedge i_rst)
      if (i_rst) r_dec <= 1'b1;
      else if (w_load) r_dec <= w_dec_ld;
`else
   assign w_dec_ld = 1'b1;
   assign w_dec    = 1'b1;
`endif
   assign w_cd = {r_d, r_c};
   always_comb begin
      for (int i = 0; i < 28; i++) begin
         w_c_pc1[i] = io_ks.i_key[6'(PC1[i] - 1)];
         w_d_pc1[i] = io_ks.i_key[6'(PC1[i + 28] - 1)];
      end
      for (int j = 0; j < 8; j++) w_bad[j] = ~^io_ks.i_key[8*j +: 8];
      for (int i = 0; i < 48; i++) w_sub[i] = w_cd[6'(PC2[i] - 1)];
   end
   assign w_load = r_state == IDLE && io_ks.i_key_valid;
   assign w_xfer = r_state == RUN && io_ks.i_subkey_ready;
   assign w_last = w_dec ? r_idx == 4'd0 : r_idx == 4'd15;
   // Decrypt undoes the shift of the current round; encrypt applies the next round's shift.
   assign w_sidx = w_dec ? r_idx : r_idx + 4'd1;
   assign w_two  = !(w_sidx == 4'd0 || w_sidx == 4'd1 || w_sidx == 4'd8 || w_sidx == 4'd15);
   always_comb begin
      w_state_nxt = r_state;
      w_c_nxt     = r_c;
      w_d_nxt     = r_d;
      w_idx_nxt   = r_idx;
      w_perr_nxt  = r_perr;
      if (w_load) begin
         w_state_nxt = RUN;
         w_c_nxt     = w_dec_ld ? w_c_pc1 : rotl(w_c_pc1, 1'b0);
         w_d_nxt     = w_dec_ld ? w_d_pc1 : rotl(w_d_pc1, 1'b0);
         w_idx_nxt   = w_dec_ld ? 4'd15 : 4'd0;
         w_perr_nxt  = PARITY_CHECK && |w_bad;
      end else if (w_xfer) begin
         if (w_last) w_state_nxt = IDLE;
         else begin
            w_c_nxt   = w_dec ? rotr(r_c, w_two) : rotl(r_c, w_two);
            w_d_nxt   = w_dec ? rotr(r_d, w_two) : rotl(r_d, w_two);
            w_idx_nxt = w_dec ? r_idx - 4'd1 : r_idx + 4'd1;
         end
      end
   end
   always_ff @(posedge i_clk or posedge i_rst)
      if (i_rst) begin
         r_state <= IDLE;
         r_c     <= '0;
         r_d     <= '0;
         r_idx   <= '0;
         r_perr  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_c     <= w_c_nxt;
         r_d     <= w_d_nxt;
         r_idx   <= w_idx_nxt;
         r_perr  <= w_perr_nxt;
      end
   assign io_ks.o_key_ready      = r_state == IDLE;
   assign io_ks.o_subkey_valid   = r_state == RUN;
   assign io_ks.o_subkey         = w_sub;
   assign io_ks.o_round_idx      = r_idx;
   assign io_ks.o_last_round     = r_state == RUN && w_last;
   assign io_ks.o_key_parity_err = r_perr;
endmodule

// File: tb/tb_des_decrypt_key_schedule.sv
// tb_des_decrypt_key_schedule: vector table plus reference-model checks of the DES key scheduler.
module tb_des_decrypt_key_schedule;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;
   des_decrypt_key_schedule_if ks();
   des_decrypt_key_schedule #(.PARITY_CHECK(1'b1)) dut (.i_clk(clk), .i_rst(rst), .io_ks(ks.slave));
   int n_cmp = 0;
   int n_bad = 0;
   localparam int PC1 [56] = '{
      57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
      10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
      14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
   localparam int PC2 [48] = '{
      14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
   localparam int SH [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
   typedef struct {
      logic [63:0] key;
      logic [47:0] k16;
      logic [47:0] k1;
      logic        perr;
      bit          rnd;
   } vec_t;
   vec_t tbl [6];
   function automatic logic [63:0] rev64(input logic [63:0] v);
      logic [63:0] r;
      for (int i = 0; i < 64; i++) r[i] = v[63 - i];
      return r;
   endfunction
   function automatic logic [47:0] rev48(input logic [47:0] v);
      logic [47:0] r;
      for (int i = 0; i < 48; i++) r[i] = v[47 - i];
      return r;
   endfunction
   // Subkey Kn from the forward FIPS schedule: C_n, D_n are C0, D0 rotated left by the cumulative shift.
   function automatic logic [47:0] model_key(input logic [63:0] key, input int round);
      int cs = 0;
      logic [55:0] cd;
      logic [47:0] k;
      for (int n = 0; n < round; n++) cs += SH[n];
      for (int i = 0; i < 28; i++) begin
         cd[i]      = key[6'(PC1[(i + cs) % 28] - 1)];
         cd[i + 28] = key[6'(PC1[28 + (i + cs) % 28] - 1)];
      end
      for (int j = 0; j < 48; j++) k[j] = cd[6'(PC2[j] - 1)];
      return k;
   endfunction
   function automatic logic model_perr(input logic [63:0] key);
      logic e = 1'b0;
      for (int j = 0; j < 8; j++) if ($countones(key[8*j +: 8]) % 2 == 0) e = 1'b1;
      return e;
   endfunction
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask
   task automatic load(input logic [63:0] key);
      chk("key_ready_before_load", 64'(ks.o_key_ready), 64'd1);
      ks.i_key       = key;
      ks.i_key_valid = 1'b1;
      @(negedge clk);
      ks.i_key_valid = 1'b0;
   endtask
   task automatic stream(input logic [63:0] key, input logic dec, input bit rnd, input logic exp_perr,
                         input string tag, output logic [47:0] last_sk);
      int got = 0;
      int cyc = 0;
      int r;
      logic rdy;
      last_sk = '0;
      while (got < 16 && cyc < 400) begin
         r   = dec ? 16 - got : got + 1;
         rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         ks.i_subkey_ready = rdy;
         chk({tag, "_valid"}, 64'(ks.o_subkey_valid), 64'd1);
         chk({tag, "_subkey"}, 64'(ks.o_subkey), 64'(model_key(key, r)));
         chk({tag, "_idx"}, 64'(ks.o_round_idx), 64'(r - 1));
         chk({tag, "_last"}, 64'(ks.o_last_round), 64'(r == (dec ? 1 : 16)));
         chk({tag, "_perr"}, 64'(ks.o_key_parity_err), 64'(exp_perr));
         if (rdy && got == 15) last_sk = ks.o_subkey;
         @(negedge clk);
         if (rdy) got++;
         cyc++;
      end
      ks.i_subkey_ready = 1'b0;
      chk({tag, "_count"}, 64'(got), 64'd16);
      if (!rnd) chk({tag, "_cycles"}, 64'(cyc), 64'd16);
      chk({tag, "_done_valid"}, 64'(ks.o_subkey_valid), 64'd0);
      chk({tag, "_done_ready"}, 64'(ks.o_key_ready), 64'd1);
   endtask
   initial begin
      logic [47:0] sk;
      logic [63:0] ka, kb;
      ks.i_key = '0;
      ks.i_key_valid = 1'b0;
      ks.i_subkey_ready = 1'b0;
`ifdef DES_KS_BIDIR_EN
      ks.i_decrypt = 1'b1;
`endif
      ka = rev64(64'h133457799BBCDFF1);
      tbl[0] = '{ka, rev48(48'hCB3D8B0E17F5), rev48(48'h1B02EFFC7072), 1'b0, 1'b0};
      tbl[1] = '{ka, rev48(48'hCB3D8B0E17F5), rev48(48'h1B02EFFC7072), 1'b0, 1'b1};
      tbl[2] = '{rev64(64'h123457799BBCDFF1), rev48(48'hCB3D8B0E17F5), rev48(48'h1B02EFFC7072), 1'b1, 1'b0};
      for (int i = 3; i < 6; i++) begin
         kb = {$urandom, $urandom};
         tbl[i] = '{kb, model_key(kb, 16), model_key(kb, 1), model_perr(kb), 1'b1};
      end
      @(negedge clk);
      chk("rst_key_ready", 64'(ks.o_key_ready), 64'd1);
      chk("rst_valid", 64'(ks.o_subkey_valid), 64'd0);
      chk("rst_subkey", 64'(ks.o_subkey), 64'd0);
      chk("rst_idx", 64'(ks.o_round_idx), 64'd0);
      chk("rst_last", 64'(ks.o_last_round), 64'd0);
      chk("rst_perr", 64'(ks.o_key_parity_err), 64'd0);
      rst = 1'b0;
      ks.i_subkey_ready = 1'b1;
      repeat (2) @(negedge clk);
      chk("idle_ready_noeffect_valid", 64'(ks.o_subkey_valid), 64'd0);
      chk("idle_ready_noeffect_kr", 64'(ks.o_key_ready), 64'd1);
      ks.i_subkey_ready = 1'b0;
      for (int v = 0; v < 6; v++) begin
         load(tbl[v].key);
         chk($sformatf("vec%0d_first_k16", v), 64'(ks.o_subkey), 64'(tbl[v].k16));
         chk($sformatf("vec%0d_key_ready_run", v), 64'(ks.o_key_ready), 64'd0);
         stream(tbl[v].key, 1'b1, tbl[v].rnd, tbl[v].perr, $sformatf("vec%0d", v), sk);
         chk($sformatf("vec%0d_last_k1", v), 64'(sk), 64'(tbl[v].k1));
      end
      load(ka);
      ks.i_subkey_ready = 1'b1;
      repeat (8) @(negedge clk);
      chk("mid_idx7", 64'(ks.o_round_idx), 64'd7);
      rst = 1'b1;
      #1;
      chk("midrst_valid", 64'(ks.o_subkey_valid), 64'd0);
      chk("midrst_key_ready", 64'(ks.o_key_ready), 64'd1);
      chk("midrst_subkey", 64'(ks.o_subkey), 64'd0);
      chk("midrst_idx", 64'(ks.o_round_idx), 64'd0);
      #1;
      rst = 1'b0;
      ks.i_subkey_ready = 1'b0;
      @(negedge clk);
      load(ka);
      stream(ka, 1'b1, 1'b0, 1'b0, "after_rst", sk);
      kb = {$urandom, $urandom};
      load(ka);
      ks.i_key = kb;
      ks.i_key_valid = 1'b1;
      stream(ka, 1'b1, 1'b1, 1'b0, "kv_in_run", sk);
      chk("kv_in_run_k1", 64'(sk), 64'(tbl[0].k1));
      @(negedge clk);
      ks.i_key_valid = 1'b0;
      chk("next_key_loaded_valid", 64'(ks.o_subkey_valid), 64'd1);
      chk("next_key_loaded_k16", 64'(ks.o_subkey), 64'(model_key(kb, 16)));
      stream(kb, 1'b1, 1'b0, model_perr(kb), "next_key", sk);
`ifdef DES_KS_BIDIR_EN
      ks.i_decrypt = 1'b0;
      load(ka);
      ks.i_decrypt = 1'b1;
      chk("enc_first_k1", 64'(ks.o_subkey), 64'(tbl[0].k1));
      stream(ka, 1'b0, 1'b1, 1'b0, "enc", sk);
      chk("enc_last_k16", 64'(sk), 64'(tbl[0].k16));
      load(ka);
      stream(ka, 1'b1, 1'b0, 1'b0, "dec_again", sk);
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
